// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Purpose  : Multi-cycle fetch/decode/execute sequencer. Owns PC and IR,
//            drives the single-port memory handshake, and gates the
//            register-file and flag write strobes one instruction at a time.
// Revision : 1.0  initial release
// ============================================================================
module instr_sequencer #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              clear,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       ir,
  output logic [ADDR_W-1:0] pc,
  input  logic              dec_alu,
  input  logic              dec_load,
  input  logic              dec_store,
  input  logic              dec_branch,
  input  logic [1:0]        dec_cond,
  input  logic              dec_illegal,
  input  logic [3:0]        status,
  input  logic [ADDR_W-1:0] target_addr,
  input  logic [ADDR_W-1:0] data_addr,
  output logic              rf_we,
  output logic              status_we,
  output logic              halted,
  output logic [1:0]        fault,
  output logic [15:0]       instr_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_phase;
  logic             timeout_hit;
  logic             branch_taken;
  logic             retire;
  logic [2:0]       end_state;
  logic             unused_status;

  // Only Z and N steer branches; the upper flags are not consulted here.
  assign unused_status = ^status[3:2];

  assign mem_phase   = (state == S_FETCH) || (state == S_MEM);
  assign timeout_hit = mem_phase && !mem_ready && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign end_state   = run ? S_FETCH : S_IDLE;

  // Bus outputs derive from state so an async reset drops the request at once.
  assign mem_req  = mem_phase;
  assign mem_we   = (state == S_MEM) && dec_store;
  assign mem_addr = (state == S_MEM) ? data_addr : pc;
  assign halted   = (state == S_HALT);

  // Branch condition evaluation from the live status flags.
  always_comb begin
    branch_taken = 1'b0;
    case (dec_cond)
      2'b00:   branch_taken = 1'b1;
      2'b01:   branch_taken = status[0];
      2'b10:   branch_taken = status[1];
      default: branch_taken = 1'b0;
    endcase
  end

  // Next-state, write-strobe and retire decisions.
  always_comb begin
    state_nx  = state;
    retire    = 1'b0;
    rf_we     = 1'b0;
    status_we = 1'b0;
    case (state)
      S_IDLE:   if (run) state_nx = S_FETCH;
      S_FETCH: begin
        if (mem_ready)        state_nx = S_DECODE;
        else if (timeout_hit) state_nx = S_HALT;
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        if (dec_illegal) begin
          state_nx = S_HALT;
        end else if (dec_branch) begin
          retire   = 1'b1;
          state_nx = end_state;
        end else if (dec_load || dec_store) begin
          state_nx = S_MEM;
        end else begin
          // ALU ops strobe both writes; an unclassified word retires as a no-op.
          rf_we     = dec_alu;
          status_we = dec_alu;
          retire    = 1'b1;
          state_nx  = end_state;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          rf_we    = dec_load && !dec_store;
          retire   = 1'b1;
          state_nx = end_state;
        end else if (timeout_hit) begin
          state_nx = S_HALT;
        end
      end
      S_HALT:   if (clear) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Wait counter: counts consecutive unanswered request cycles, cleared otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    wait_cnt <= '0;
    else if (mem_phase && !mem_ready) wait_cnt <= wait_cnt + CNT_W'(1);
    else                             wait_cnt <= '0;
  end

  // PC and IR: capture on fetch accept, redirect on a taken branch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_PC;
      ir <= '0;
    end else if (state == S_FETCH && mem_ready) begin
      ir <= mem_rdata;
      pc <= pc + ADDR_W'(1);
    end else if (state == S_EXEC && !dec_illegal && dec_branch && branch_taken) begin
      pc <= target_addr;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    instr_count <= '0;
    else if (retire) instr_count <= instr_count + 16'd1;
  end

  // Fault code: set on illegal opcode or bus timeout, cleared when leaving HALT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            fault <= 2'b00;
    else if (state == S_EXEC && dec_illegal) fault <= 2'b01;
    else if (timeout_hit)                    fault <= 2'b10;
    else if (state == S_HALT && clear)       fault <= 2'b00;
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Purpose  : Directed self-checking bench for instr_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic        clear;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic [15:0] ir;
  logic [15:0] pc;
  logic        dec_alu;
  logic        dec_load;
  logic        dec_store;
  logic        dec_branch;
  logic [1:0]  dec_cond;
  logic        dec_illegal;
  logic [3:0]  status;
  logic [15:0] target_addr;
  logic [15:0] data_addr;
  logic        rf_we;
  logic        status_we;
  logic        halted;
  logic [1:0]  fault;
  logic [15:0] instr_count;

  int checks = 0;
  int passes = 0;

  instr_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000), .TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .clear(clear),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .ir(ir), .pc(pc),
    .dec_alu(dec_alu), .dec_load(dec_load), .dec_store(dec_store),
    .dec_branch(dec_branch), .dec_cond(dec_cond), .dec_illegal(dec_illegal),
    .status(status), .target_addr(target_addr), .data_addr(data_addr),
    .rf_we(rf_we), .status_we(status_we), .halted(halted), .fault(fault),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0; clear = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    dec_alu = 1'b0; dec_load = 1'b0; dec_store = 1'b0; dec_branch = 1'b0;
    dec_cond = 2'b00; dec_illegal = 1'b0; status = '0; target_addr = '0; data_addr = '0;
    tick(); tick();
    check("rst_pc", pc, 0);
    check("rst_ir", ir, 0);
    check("rst_count", instr_count, 0);
    check("rst_fault", fault, 0);
    check("rst_req", mem_req, 0);
    check("rst_halted", halted, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_status_we", status_we, 0);
    reset_n = 1'b1;
    tick();
    check("idle_no_req", mem_req, 0);

    // ALU instruction, zero-wait fetch
    run = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h6101; dec_alu = 1'b1;
    tick();                                   // FETCH
    check("alu_fetch_req", mem_req, 1);
    check("alu_fetch_addr", mem_addr, 16'h0000);
    check("alu_fetch_we", mem_we, 0);
    tick();                                   // DECODE
    check("alu_ir", ir, 16'h6101);
    check("alu_pc", pc, 16'h0001);
    check("alu_dec_rf_we", rf_we, 0);
    check("alu_dec_req", mem_req, 0);
    tick();                                   // EXEC
    check("alu_rf_we", rf_we, 1);
    check("alu_status_we", status_we, 1);
    tick();                                   // FETCH @1
    check("alu_rf_we_off", rf_we, 0);
    check("alu_status_we_off", status_we, 0);
    check("alu_count", instr_count, 1);
    check("alu_next_addr", mem_addr, 16'h0001);

    // BRZ taken
    mem_rdata = 16'hC040; dec_alu = 1'b0; dec_branch = 1'b1; dec_cond = 2'b01;
    status = 4'b0001; target_addr = 16'h0040;
    tick(); tick();                           // DECODE, EXEC
    check("brz_rf_we", rf_we, 0);
    tick();                                   // FETCH @0x40
    check("brz_taken_addr", mem_addr, 16'h0040);
    check("brz_taken_count", instr_count, 2);
    // BRZ not taken
    status = 4'b0000;
    tick(); tick(); tick();
    check("brz_not_taken_addr", mem_addr, 16'h0041);
    check("brz_not_taken_count", instr_count, 3);

    // Load with three wait cycles
    mem_rdata = 16'h8000; dec_branch = 1'b0; dec_cond = 2'b00; dec_load = 1'b1;
    data_addr = 16'h0100;
    tick();                                   // DECODE
    mem_ready = 1'b0;
    tick(); tick();                           // EXEC, MEM
    for (int i = 0; i < 3; i++) begin
      check("ld_wait_req", mem_req, 1);
      check("ld_wait_addr", mem_addr, 16'h0100);
      check("ld_wait_we", mem_we, 0);
      check("ld_wait_rf_we", rf_we, 0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("ld_ready_rf_we", rf_we, 1);
    check("ld_ready_addr", mem_addr, 16'h0100);
    tick();                                   // FETCH @0x42
    check("ld_rf_we_off", rf_we, 0);
    check("ld_next_addr", mem_addr, 16'h0042);
    check("ld_count", instr_count, 4);

    // Store
    dec_load = 1'b0; dec_store = 1'b1; data_addr = 16'h0200; mem_rdata = 16'h9000;
    tick();                                   // DECODE
    mem_ready = 1'b0;
    tick(); tick();                           // EXEC, MEM
    check("st_we", mem_we, 1);
    check("st_addr", mem_addr, 16'h0200);
    mem_ready = 1'b1;
    #1;
    check("st_rf_we", rf_we, 0);
    check("st_status_we", status_we, 0);
    tick();                                   // FETCH @0x43
    check("st_count", instr_count, 5);
    check("st_next_addr", mem_addr, 16'h0043);

    // Fetch timeout
    dec_store = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check("to_wait_req", mem_req, 1);
      check("to_wait_halted", halted, 0);
      tick();
    end
    check("to_halted", halted, 1);
    check("to_fault", fault, 2'b10);
    check("to_req", mem_req, 0);
    check("to_pc", pc, 16'h0043);
    tick();
    check("halt_ignores_run", halted, 1);
    check("halt_no_req", mem_req, 0);
    clear = 1'b1;
    tick();                                   // IDLE
    clear = 1'b0;
    check("clear_halted", halted, 0);
    check("clear_fault", fault, 0);
    check("clear_no_req", mem_req, 0);

    // Illegal instruction (ALU also decoded, illegal must win)
    dec_illegal = 1'b1; dec_alu = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h0000;
    tick();                                   // FETCH @0x43
    check("ill_fetch_addr", mem_addr, 16'h0043);
    tick(); tick();                           // DECODE, EXEC
    check("ill_rf_we", rf_we, 0);
    check("ill_status_we", status_we, 0);
    tick();                                   // HALT
    check("ill_halted", halted, 1);
    check("ill_fault", fault, 2'b01);
    check("ill_count", instr_count, 5);
    check("ill_pc", pc, 16'h0044);
    clear = 1'b1;
    tick();                                   // IDLE
    clear = 1'b0;

    // Async reset during MEM wait
    dec_illegal = 1'b0; dec_alu = 1'b0; dec_load = 1'b1; data_addr = 16'h0300;
    tick();                                   // FETCH @0x44
    tick();                                   // DECODE
    mem_ready = 1'b0;
    tick(); tick();                           // EXEC, MEM
    check("rstmem_req", mem_req, 1);
    check("rstmem_addr", mem_addr, 16'h0300);
    run = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rstmem_req_drop", mem_req, 0);
    check("rstmem_pc", pc, 16'h0000);
    check("rstmem_ir", ir, 16'h0000);
    check("rstmem_count", instr_count, 0);
    #2;
    reset_n = 1'b1;
    tick();
    check("rstmem_idle", mem_req, 0);

    // run dropped mid-instruction: finish it, then idle
    run = 1'b1; dec_load = 1'b0; dec_alu = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h6202;
    tick();                                   // FETCH @0
    check("stop_fetch_addr", mem_addr, 16'h0000);
    run = 1'b0;
    tick(); tick();                           // DECODE, EXEC
    check("stop_rf_we", rf_we, 1);
    tick();                                   // IDLE
    check("stop_no_req", mem_req, 0);
    check("stop_count", instr_count, 1);
    check("stop_pc", pc, 16'h0001);
    tick(); tick();
    check("stop_still_idle", mem_req, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
